// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: flit field layout, port indices
// and the output-arbiter state encoding.
package noc_pkg;

    localparam int FLIT_W   = 37;
    localparam int DATA_MSB = 36;
    localparam int DATA_LSB = 5;
    localparam int END_BIT  = 4;
    localparam int DEST_MSB = 3;
    localparam int DEST_LSB = 0;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    localparam int NPORTS = 5;
    localparam int IDX_W  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic flit_is_end(input logic [FLIT_W-1:0] flit);
        return flit[END_BIT];
    endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Round-robin picker: first set request searching upward from last_i + 1,
// wrapping modulo NREQ. Purely combinational.
module noc_rr_pick
    import noc_pkg::*;
#(
    parameter int NREQ  = 5,
    parameter int PIDX_W = 3
) (
    input  logic [NREQ-1:0]   req_i,
    input  logic [PIDX_W-1:0] last_i,
    output logic              found_o,
    output logic [PIDX_W-1:0] idx_o
);

    // Walk candidates farthest-first so the nearest hit after last_i wins
    always_comb begin
        int cand;
        cand    = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand    = (int'(last_i) + k) % NREQ;
            found_o = found_o | req_i[PIDX_W'(cand)];
            idx_o   = req_i[PIDX_W'(cand)] ? PIDX_W'(cand) : idx_o;
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-output-port wormhole arbiter with a one-entry registered output buffer.
// A granted input owns the link until its end-bit flit enters the buffer.
module noc_out_arbiter
    import noc_pkg::*;
#(
    parameter int NREQ   = 5,
    parameter int FLIT_W = 37,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*FLIT_W-1:0] req_flit,
    output logic [NREQ-1:0]        req_ready,
    output logic                   out_valid,
    output logic [FLIT_W-1:0]      out_flit,
    input  logic                   out_ready,
    output logic [2:0]             grant_idx,
    output logic                   busy,
    output logic [CNT_W-1:0]       pkt_cnt
);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pick_found_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                sel_valid_s;
    logic [FLIT_W-1:0]   sel_flit_s;
    logic                locked_s;
    logic                can_load_s;
    logic                xfer_s;

    noc_rr_pick #(
        .NREQ   (NREQ),
        .PIDX_W (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .found_o (pick_found_s),
        .idx_o   (pick_idx_s)
    );

    assign locked_s   = (state_q == ST_LOCKED);
    // Buffer can take a flit when empty or when it drains this same cycle
    assign can_load_s = !out_valid_q || out_ready;
    assign xfer_s     = locked_s && sel_valid_s && can_load_s;

    // Mux out the valid and flit of the currently granted input
    always_comb begin
        sel_valid_s = 1'b0;
        sel_flit_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_valid_s = (grant_q == IDX_W'(i)) ? req_valid[i] : sel_valid_s;
            sel_flit_s  = (grant_q == IDX_W'(i)) ? req_flit[i*FLIT_W +: FLIT_W] : sel_flit_s;
        end
    end

    // Handshake back to the inputs; only the lock owner may be consumed
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = locked_s && (grant_q == IDX_W'(i)) && req_valid[i] && can_load_s;
        end
    end

    // Next-state: arbitration, lock release and output buffer update
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_idx_s;
                    state_d = ST_LOCKED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && flit_is_end(sel_flit_s)) begin
                    last_d  = grant_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (xfer_s) begin
            out_flit_d  = sel_flit_s;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers; reset drops any partial packet at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= IDX_W'(NREQ - 1);
            cnt_q       <= '0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign grant_idx = grant_q;
    assign busy      = locked_s;
    assign pkt_cnt   = cnt_q;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Scoreboard bench for noc_out_arbiter: packet sources per input, expected
// flits queued in service order and compared as they leave the buffer.
module tb_noc_out_arbiter;

    localparam int NREQ = 5;
    localparam int FW   = 37;
    localparam int CW   = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*FW-1:0]   req_flit;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [FW-1:0]        out_flit;
    logic                 out_ready;
    logic [2:0]           grant_idx;
    logic                 busy;
    logic [CW-1:0]        pkt_cnt;

    logic [FW-1:0]        src_q [NREQ][$];
    logic [FW-1:0]        exp_q [$];
    logic [NREQ-1:0]      hold;
    logic [NREQ-1:0]      hs;
    logic                 ordy_want;
    int                   n_checks = 0;
    int                   n_fail   = 0;

    noc_out_arbiter #(.NREQ(NREQ), .FLIT_W(FW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_flit  (req_flit),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .grant_idx (grant_idx),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Flit k of an n-flit packet: end bit on the last one, dest = low nibble of data
    function automatic logic [FW-1:0] pk(input logic [31:0] base, input int k, input int n);
        logic [31:0] d;
        d = base + 32'(k);
        return {d, (k == n - 1), d[3:0]};
    endfunction

    task automatic send(input int port, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            src_q[port].push_back(pk(base, k, n));
            exp_q.push_back(pk(base, k, n));
        end
    endtask

    // One clock: advance sources after the edge, then sample and score at negedge
    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = ordy_want;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            req_valid[i] = (src_q[i].size() > 0) && !hold[i];
            req_flit[i*FW +: FW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
        @(negedge clk);
        hs = req_valid & req_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check_eq("spurious_out", 64'(exp_q.size()), 64'd1);
            else
                check_eq("out_flit", 64'(out_flit), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        hold      = '0;
        hs        = '0;
        req_valid = '0;
        req_flit  = '0;
        ordy_want = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_flit",  64'(out_flit),  64'd0);
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_grant",     64'(grant_idx), 64'd0);
        check_eq("rst_pkt_cnt",   64'(pkt_cnt),   64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_drained();
        tick();
        tick();
        check_eq("drain_q",   64'(exp_q.size()), 64'd0);
        check_eq("drain_val", 64'(out_valid),    64'd0);
    endtask

    initial begin
        int order [6];
        reset     = 1'b1;
        req_valid = '0;
        req_flit  = '0;
        out_ready = 1'b1;
        ordy_want = 1'b1;
        hold      = '0;
        hs        = '0;
        do_reset();

        // 1: single-flit packet latency from input L
        send(0, 1, 32'hCAFE_0015);
        tick();
        check_eq("t1_c0_busy",  64'(busy),      64'd0);
        check_eq("t1_c0_rdy",   64'(req_ready), 64'd0);
        tick();
        check_eq("t1_c1_busy",  64'(busy),      64'd1);
        check_eq("t1_c1_grant", 64'(grant_idx), 64'd0);
        check_eq("t1_c1_rdy",   64'(req_ready), 64'b00001);
        tick();
        check_eq("t1_c2_valid", 64'(out_valid), 64'd1);
        check_eq("t1_c2_flit",  64'(out_flit),  64'(pk(32'hCAFE_0015, 0, 1)));
        check_eq("t1_c2_cnt",   64'(pkt_cnt),   64'd1);
        check_eq("t1_c2_busy",  64'(busy),      64'd0);
        expect_drained();

        // 2: all inputs requesting continuously, rotation 0..4,0
        do_reset();
        send(0, 1, 32'h0000_0200);
        send(1, 1, 32'h0000_0221);
        send(2, 1, 32'h0000_0232);
        send(3, 1, 32'h0000_0243);
        send(4, 1, 32'h0000_0254);
        send(0, 1, 32'h0000_0260);
        order = '{0, 1, 2, 3, 4, 0};
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c % 2 == 1) begin
                check_eq("t2_grant", 64'(grant_idx), 64'(order[c/2]));
                check_eq("t2_rdy",   64'(req_ready), 64'(5'b00001 << order[c/2]));
            end else begin
                check_eq("t2_idle_busy", 64'(busy),      64'd0);
                check_eq("t2_idle_rdy",  64'(req_ready), 64'd0);
            end
        end
        tick();
        check_eq("t2_cnt", 64'(pkt_cnt), 64'd6);
        expect_drained();

        // 3: 3-flit wormhole from E must not be interleaved with S
        send(2, 3, 32'h0000_0300);
        send(3, 1, 32'h0000_0310);
        tick();
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_eq("t3_grant", 64'(grant_idx), 64'd2);
            check_eq("t3_rdy",   64'(req_ready), 64'b00100);
        end
        tick();
        check_eq("t3_gap_busy", 64'(busy), 64'd0);
        tick();
        check_eq("t3_grant_s", 64'(grant_idx), 64'd3);
        check_eq("t3_rdy_s",   64'(req_ready), 64'b01000);
        expect_drained();

        // 4: owner stalls mid-packet, competing N must wait
        send(2, 3, 32'h0000_0400);
        tick();
        tick();
        check_eq("t4_grant0", 64'(grant_idx), 64'd2);
        hold[2] = 1'b1;
        send(1, 1, 32'h0000_0411);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("t4_hold_busy",  64'(busy),      64'd1);
            check_eq("t4_hold_grant", 64'(grant_idx), 64'd2);
            check_eq("t4_hold_rdy",   64'(req_ready), 64'd0);
        end
        hold[2] = 1'b0;
        tick();
        check_eq("t4_resume_rdy", 64'(req_ready), 64'b00100);
        tick();
        check_eq("t4_end_rdy", 64'(req_ready), 64'b00100);
        tick();
        check_eq("t4_gap_busy", 64'(busy), 64'd0);
        tick();
        check_eq("t4_grant_n", 64'(grant_idx), 64'd1);
        expect_drained();

        // 5: downstream backpressure holds the buffer, then reloads without a bubble
        send(4, 3, 32'h0000_0500);
        tick();
        tick();
        check_eq("t5_grant", 64'(grant_idx), 64'd4);
        ordy_want = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("t5_bp_valid", 64'(out_valid), 64'd1);
            check_eq("t5_bp_flit",  64'(out_flit),  64'(pk(32'h0000_0500, 0, 3)));
            check_eq("t5_bp_rdy",   64'(req_ready), 64'd0);
        end
        ordy_want = 1'b1;
        tick();
        check_eq("t5_rel_rdy", 64'(req_ready), 64'b10000);
        tick();
        check_eq("t5_nobubble_valid", 64'(out_valid), 64'd1);
        check_eq("t5_nobubble_flit",  64'(out_flit),  64'(pk(32'h0000_0500, 1, 3)));
        tick();
        check_eq("t5_last_flit", 64'(out_flit), 64'(pk(32'h0000_0500, 2, 3)));
        check_eq("t5_cnt", 64'(pkt_cnt), 64'd11);
        expect_drained();

        // 6: reset in the middle of a 4-flit packet, then fresh priority from L
        send(3, 4, 32'h0000_0600);
        tick();
        tick();
        tick();
        check_eq("t6_pre_busy", 64'(busy), 64'd1);
        do_reset();
        send(1, 1, 32'h0000_0701);
        send(3, 1, 32'h0000_0713);
        tick();
        check_eq("t6_c0_busy", 64'(busy), 64'd0);
        tick();
        check_eq("t6_grant_low", 64'(grant_idx), 64'd1);
        tick();
        tick();
        check_eq("t6_grant_next", 64'(grant_idx), 64'd3);
        expect_drained();
        check_eq("t6_cnt", 64'(pkt_cnt), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
- Per-output-port arbiter and output stage for the 5-port mesh router (ports L, N, E, S, W).
- Shares one router output link between up to NREQ input ports.
- Grants are round-robin and wormhole-locked: once granted, an input owns the output until its flit with end bit = 1 has been transferred.
- Drives a one-entry registered output buffer toward the neighbouring cell or the local CPU.

Parameters:
- NREQ, 5, number of requesting input ports (index 0 = L, 1 = N, 2 = E, 3 = S, 4 = W).
- FLIT_W, 37, flit width: [36:5] data, [4] end bit, [3:0] destination address.
- CNT_W, 16, width of the transferred-packet counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  input i holds a flit routed to this output
- req_flit  in  NREQ*FLIT_W  flits; input i occupies bits [i*FLIT_W +: FLIT_W]
- req_ready  out  NREQ  flit of input i is consumed this cycle when req_valid[i] is also 1
- out_valid  out  1  out_flit is valid
- out_flit  out  FLIT_W  registered output flit
- out_ready  in  1  downstream accepts out_flit this cycle
- grant_idx  out  3  currently locked input index; meaningful only when busy = 1
- busy  out  1  arbiter in LOCKED state
- pkt_cnt  out  CNT_W  count of completed packets (end-bit flits accepted into the buffer)

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values:
  - out_valid = 0, out_flit = 0, busy = 0, grant_idx = 0, pkt_cnt = 0.
  - Last-grant pointer = NREQ-1, so index 0 has first priority.
- State IDLE:
  - If any req_valid is set, choose the first set index searching from (last + 1) mod NREQ upward, wrapping.
  - Register that index into grant_idx and go to LOCKED. Arbitration costs exactly one cycle.
  - req_ready = 0 for all inputs in IDLE.
- State LOCKED:
  - req_ready[g] = req_valid[g] && (!out_valid || out_ready), where g = grant_idx. All other req_ready bits are 0.
  - req_ready is combinational from out_ready.
  - On transfer (req_valid[g] && req_ready[g]): out_flit <= req_flit[g], out_valid <= 1.
  - On transfer with flit bit 4 = 1: last <= g, pkt_cnt <= pkt_cnt + 1 (wraps modulo 2^CNT_W), next state IDLE.
  - If req_valid[g] drops mid-packet, stay LOCKED holding the grant. No timeout.
- Output buffer:
  - When out_valid && out_ready and no new transfer occurs, out_valid <= 0.
  - When out_valid && out_ready and a transfer occurs in the same cycle, the buffer is reloaded with no bubble.
  - When out_valid && !out_ready, out_flit is held stable.
- Latency: req_valid rises in IDLE at cycle 0 -> grant registered at the end of cycle 0 -> req_ready high in cycle 1 -> out_valid high in cycle 2.
- Throughput: 1 flit/cycle within a packet; one idle arbitration cycle between packets.
- Single-flit packet (end bit set on the head flit): lock lasts one transfer cycle.
- Simultaneous events:
  - A request arriving in the same cycle the packet ends is not served in that cycle; it is arbitrated in the following IDLE cycle.
  - After a grant to g, priority starts at g+1, so no input can starve a continuously requesting neighbour.
- Reset mid-packet: the lock, buffer and counter are cleared immediately (asynchronous); the partial packet is lost. Recovery is the upstream's responsibility.
- Destination bits [3:0] are not interpreted; routing is done upstream.

Decomposition:
- Shared package noc_pkg:
  - FLIT_W = 37, DATA_MSB = 36, DATA_LSB = 5, END_BIT = 4, DEST_MSB = 3, DEST_LSB = 0.
  - Port index constants PORT_L = 0, PORT_N = 1, PORT_E = 2, PORT_S = 3, PORT_W = 4.
  - State encoding ST_IDLE / ST_LOCKED.
- Sub-module noc_rr_pick: combinational. Inputs: req vector and last pointer. Outputs: found and index. Reused by the future input-side allocator.

Test Plan:
1. Reset, then req_valid = 5'b00001 with a single flit 0x...1_5 (end = 1, dest = 5) -> grant_idx = 0 at cycle 1, req_ready[0] at cycle 1, out_valid with the same flit at cycle 2, pkt_cnt = 1, busy = 0 at cycle 2.
2. All 5 inputs hold single-flit packets continuously, out_ready = 1 -> grant order 0, 1, 2, 3, 4, 0; exactly one packet every 2 cycles; pkt_cnt = 6 after 12 cycles.
3. Input 2 sends a 3-flit packet (end bits 0, 0, 1) while input 3 requests -> the 3 flits appear consecutively on out_flit, none from input 3 interleaved; input 3 is granted only after input 2's end flit.
4. Input 2 locked, req_valid[2] drops for 4 cycles mid-packet while input 1 requests -> busy stays 1, grant_idx stays 2, req_ready[1] stays 0.
5. out_ready = 0 for 3 cycles with out_valid = 1 -> out_flit stable, req_ready[g] = 0; on out_ready = 1 the next flit loads in the same cycle with no bubble.
6. Assert reset in the middle of a 4-flit packet -> out_valid = 0, busy = 0 and pkt_cnt = 0 immediately; the next grant goes to the lowest-index requester.
